calc_sequencer: RTL and testbench

Micro-sequencer that runs small stored programs on the 8-register simple calculator. It holds a program RAM of instruction words and fetches and executes them one at a time. For each executed instruction it drives the calculator's WEN/RW/RX/RY/DataIn/Sel/Ctrl inputs, and it observes the calculator's busY and Carry outputs for conditional branches and flag capture. It sits between the host/testbench control port and the calculator instance. It replaces hand-driven per-cycle stimulus with load-then-Start operation.

---
 rtl/calc_seq_pkg.sv | 54 +++++
 rtl/calc_prog_ram.sv | 44 ++++
 rtl/calc_sequencer.sv | 184 ++++++++++++++++++
 tb/tb_calc_sequencer.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/calc_seq_pkg.sv
// Shared definitions for the calculator micro-sequencer.
// Contents: instruction kind encodings, instruction field bit positions,
// calculator Ctrl opcodes used for carry capture, the FSM state enum and the
// packed instruction layout.
package calc_seq_pkg;

    localparam int unsigned InstrW  = 26;

    // Instruction field bit positions (LSB of each field).
    localparam int unsigned KindLsb = 24;
    localparam int unsigned CtrlLsb = 20;
    localparam int unsigned SelBit  = 19;
    localparam int unsigned WeBit   = 18;
    localparam int unsigned RwLsb   = 15;
    localparam int unsigned RxLsb   = 12;
    localparam int unsigned RyLsb   = 9;
    localparam int unsigned RsvdBit = 8;
    localparam int unsigned ImmLsb  = 0;

    typedef enum logic [1:0] {
        KindExec = 2'b00,
        KindBrz  = 2'b01,
        KindJmp  = 2'b10,
        KindHalt = 2'b11
    } kind_e;

    localparam logic [3:0] CtrlAdd = 4'b0000;
    localparam logic [3:0] CtrlSub = 4'b0001;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StFetch = 2'd1,
        StExec  = 2'd2
    } state_e;

    // Field order matches the bit positions above, MSB first.
    typedef struct packed {
        kind_e       kind;
        logic [3:0]  ctrl;
        logic        sel;
        logic        we;
        logic [2:0]  rw;
        logic [2:0]  rx;
        logic [2:0]  ry;
        logic        rsvd;
        logic [7:0]  imm;
    } instr_t;

    // Only ADD and SUB produce a meaningful carry/borrow.
    function automatic logic is_carry_op(input logic [3:0] ctrl);
        return (ctrl == CtrlAdd) || (ctrl == CtrlSub);
    endfunction

endpackage

// File: rtl/calc_prog_ram.sv
// Program RAM for the sequencer: DEPTH x DW words, one synchronous write port
// and one read port whose output register doubles as the instruction register.
// Ports:
//   i_clk, i_rst_n      clock, synchronous active-low reset (read register only)
//   i_we, i_waddr,      write strobe, address, data
//   i_wdata
//   i_re, i_raddr       read enable and address; data lands in o_rdata next edge
//   o_rdata             registered read data (IR)
module calc_prog_ram #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned AW    = 4,
    parameter int unsigned DW    = 26
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [DW-1:0] i_wdata,
    input  logic          i_re,
    input  logic [AW-1:0] i_raddr,
    output logic [DW-1:0] o_rdata
);

    logic [DW-1:0] r_mem [DEPTH];
    logic [DW-1:0] r_rdata;

    // Storage has no reset so programs survive Rst_n.
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_rdata <= '0;
        end else if (i_re) begin
            r_rdata <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/calc_sequencer.sv
// Micro-sequencer that fetches and executes stored programs on the 8-register
// calculator. Each instruction takes a FETCH and an EXEC cycle; calculator
// controls are driven only during EXEC.
// Ports:
//   Clk, Rst_n                  clock, synchronous active-low reset
//   ProgWe, ProgAddr, ProgData  program load port (ignored while Busy)
//   Start                       begin run at PC=0 (ignored while Busy)
//   Busy, Done, Err             run status; Done pulses, Err holds until Start
//   CarryFlag, Steps            sticky carry and executed-instruction count
//   WEN, RW, RX, RY, DataIn,    calculator controls
//   Sel, Ctrl
//   busY, Carry                 calculator read bus and carry
module calc_sequencer
    import calc_seq_pkg::*;
#(
    parameter int unsigned DEPTH     = 16,
    parameter int unsigned AW        = 4,
    parameter int unsigned MAX_STEPS = 255
) (
    input  logic          Clk,
    input  logic          Rst_n,
    input  logic          ProgWe,
    input  logic [AW-1:0] ProgAddr,
    input  logic [25:0]   ProgData,
    input  logic          Start,
    output logic          Busy,
    output logic          Done,
    output logic          Err,
    output logic          CarryFlag,
    output logic [7:0]    Steps,
    output logic          WEN,
    output logic [2:0]    RW,
    output logic [2:0]    RX,
    output logic [2:0]    RY,
    output logic [7:0]    DataIn,
    output logic          Sel,
    output logic [3:0]    Ctrl,
    input  logic [7:0]    busY,
    input  logic          Carry
);

    state_e              r_state;
    state_e              w_state_next;
    logic [AW-1:0]       r_pc;
    logic [AW-1:0]       w_pc_inc;
    logic [AW-1:0]       w_pc_next;
    logic [7:0]          r_steps;
    logic [7:0]          w_steps_inc;
    logic                r_done;
    logic                r_err;
    logic                r_carry_flag;
    logic [InstrW-1:0]   w_ir_raw;
    instr_t              w_ir;
    logic                w_idle;
    logic                w_fetch;
    logic                w_exec;
    logic                w_prog_we;
    logic                w_halt;
    logic                w_wd_hit;
    logic                w_run_end;
    logic                w_carry_set;
    logic                w_unused_rsvd;

    assign w_idle    = (r_state == StIdle);
    assign w_fetch   = (r_state == StFetch);
    assign w_exec    = (r_state == StExec);
    assign w_prog_we = ProgWe && w_idle;

    calc_prog_ram #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .DW    (InstrW)
    ) u_prog_ram (
        .i_clk   (Clk),
        .i_rst_n (Rst_n),
        .i_we    (w_prog_we),
        .i_waddr (ProgAddr),
        .i_wdata (ProgData),
        .i_re    (w_fetch),
        .i_raddr (r_pc),
        .o_rdata (w_ir_raw)
    );

    assign w_ir          = instr_t'(w_ir_raw);
    assign w_unused_rsvd = w_ir.rsvd;

    assign w_halt      = (w_ir.kind == KindHalt);
    assign w_steps_inc = r_steps + 8'd1;
    // Watchdog trips on the instruction that brings Steps to the limit, unless
    // that instruction is itself the HALT.
    assign w_wd_hit    = (w_steps_inc == MAX_STEPS[7:0]) && !w_halt;
    assign w_run_end   = w_halt || w_wd_hit;
    assign w_carry_set = (w_ir.kind == KindExec) && w_ir.we && is_carry_op(w_ir.ctrl) && Carry;

    // PC wraps naturally in AW bits.
    assign w_pc_inc = r_pc + AW'(1);

    always_comb begin
        w_pc_next = w_pc_inc;
        case (w_ir.kind)
            KindBrz:  w_pc_next = (busY == 8'h00) ? w_ir.imm[AW-1:0] : w_pc_inc;
            KindJmp:  w_pc_next = w_ir.imm[AW-1:0];
            default:  w_pc_next = w_pc_inc;
        endcase
    end

    // FSM state register.
    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FSM next state.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            StIdle:  if (Start) w_state_next = StFetch;
            StFetch: w_state_next = StExec;
            StExec:  w_state_next = w_run_end ? StIdle : StFetch;
            default: w_state_next = StIdle;
        endcase
    end

    // Run bookkeeping: PC, step count, status flags.
    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            r_pc         <= '0;
            r_steps      <= '0;
            r_done       <= 1'b0;
            r_err        <= 1'b0;
            r_carry_flag <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_idle && Start) begin
                r_pc         <= '0;
                r_steps      <= '0;
                r_err        <= 1'b0;
                r_carry_flag <= 1'b0;
            end else if (w_exec) begin
                r_pc    <= w_pc_next;
                r_steps <= w_steps_inc;
                if (w_wd_hit)    r_err        <= 1'b1;
                if (w_run_end)   r_done       <= 1'b1;
                if (w_carry_set) r_carry_flag <= 1'b1;
            end
        end
    end

    // FSM outputs: calculator controls are live only during EXEC.
    always_comb begin
        WEN    = 1'b0;
        RW     = '0;
        RX     = '0;
        RY     = '0;
        DataIn = '0;
        Sel    = 1'b0;
        Ctrl   = '0;
        if (w_exec) begin
            case (w_ir.kind)
                KindExec: begin
                    WEN    = w_ir.we;
                    RW     = w_ir.rw;
                    RX     = w_ir.rx;
                    RY     = w_ir.ry;
                    DataIn = w_ir.imm;
                    Sel    = w_ir.sel;
                    Ctrl   = w_ir.ctrl;
                end
                KindBrz:  RY = w_ir.ry;
                default:  ;
            endcase
        end
    end

    assign Busy      = !w_idle;
    assign Done      = r_done;
    assign Err       = r_err;
    assign CarryFlag = r_carry_flag;
    assign Steps     = r_steps;

endmodule

// File: tb/tb_calc_sequencer.sv
// Scoreboard bench for calc_sequencer with a behavioural 8-register calculator.
module tb_calc_sequencer;

    localparam logic [1:0] K_EXEC = 2'b00;
    localparam logic [1:0] K_BRZ  = 2'b01;
    localparam logic [1:0] K_JMP  = 2'b10;
    localparam logic [1:0] K_HALT = 2'b11;
    localparam logic [3:0] C_ADD  = 4'b0000;
    localparam logic [3:0] C_SUB  = 4'b0001;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        prog_we;
    logic [3:0]  prog_addr;
    logic [25:0] prog_data;
    logic        start;
    logic        busy, done, err, carry_flag;
    logic [7:0]  steps;
    logic        wen, sel;
    logic [2:0]  rw, rx, ry;
    logic [7:0]  data_in;
    logic [3:0]  ctrl;
    logic [7:0]  bus_y;
    logic        carry;

    always #5 clk = ~clk;

    calc_sequencer #(
        .DEPTH     (16),
        .AW        (4),
        .MAX_STEPS (255)
    ) dut (
        .Clk       (clk),
        .Rst_n     (rst_n),
        .ProgWe    (prog_we),
        .ProgAddr  (prog_addr),
        .ProgData  (prog_data),
        .Start     (start),
        .Busy      (busy),
        .Done      (done),
        .Err       (err),
        .CarryFlag (carry_flag),
        .Steps     (steps),
        .WEN       (wen),
        .RW        (rw),
        .RX        (rx),
        .RY        (ry),
        .DataIn    (data_in),
        .Sel       (sel),
        .Ctrl      (ctrl),
        .busY      (bus_y),
        .Carry     (carry)
    );

    // Calculator model: Y = R[RX] op (Sel ? R[RY] : DataIn); busY = R[RY].
    logic [7:0] regs [8];
    logic       calc_clr;
    logic [7:0] m_a, m_b;
    logic [8:0] m_full;

    always_comb begin
        m_a = regs[rx];
        m_b = sel ? regs[ry] : data_in;
        if (ctrl == C_SUB) m_full = {1'b0, m_a} - {1'b0, m_b};
        else               m_full = {1'b0, m_a} + {1'b0, m_b};
        carry = m_full[8];
        bus_y = regs[ry];
    end

    always @(posedge clk) begin
        if (calc_clr) begin
            for (int i = 0; i < 8; i++) regs[i] <= 8'h00;
        end else if (wen) begin
            regs[rw] <= m_full[7:0];
        end
    end

    int cyc = 0;
    int wen_cnt = 0;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (wen) wen_cnt <= wen_cnt + 1;

    typedef struct {
        string      name;
        int         start;
        int         lat;
        logic [7:0] steps;
        logic       err;
        logic       cf;
        int         ridx;
        logic [7:0] rval;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act === expv) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, expv);
    endtask

    function automatic logic [25:0] enc(input logic [1:0] k, input logic [3:0] c, input logic s,
                                        input logic we, input logic [2:0] w, input logic [2:0] x,
                                        input logic [2:0] y, input logic [7:0] imm);
        return {k, c, s, we, w, x, y, 1'b0, imm};
    endfunction

    task automatic wr(input logic [3:0] a, input logic [25:0] d);
        @(negedge clk);
        prog_we = 1'b1; prog_addr = a; prog_data = d;
        @(negedge clk);
        prog_we = 1'b0;
    endtask

    task automatic start_run(input bit push, input string nm, input int lat, input logic [7:0] st,
                             input logic er, input logic cf, input int ridx, input logic [7:0] rv,
                             input bit with_we, input logic [3:0] a, input logic [25:0] d);
        exp_t e;
        @(negedge clk);
        start = 1'b1;
        if (with_we) begin
            prog_we = 1'b1; prog_addr = a; prog_data = d;
        end
        if (push) begin
            e.name = nm; e.start = cyc + 1; e.lat = lat; e.steps = st;
            e.err = er; e.cf = cf; e.ridx = ridx; e.rval = rv;
            exp_q.push_back(e);
        end
        @(negedge clk);
        start = 1'b0; prog_we = 1'b0;
    endtask

    task automatic wait_run(input string nm, input int budget);
        for (int i = 0; i < budget && exp_q.size() != 0; i++) @(negedge clk);
        @(negedge clk);
        if (exp_q.size() != 0) begin
            n_checks++;
            $display("FAIL %s_timeout: no Done within %0d cycles", nm, budget);
            exp_q.delete();
        end
    endtask

    task automatic load_countdown();
        wr(4'd0, enc(K_EXEC, C_ADD, 1'b0, 1'b1, 3'd1, 3'd0, 3'd0, 8'd3));
        wr(4'd1, enc(K_EXEC, C_ADD, 1'b0, 1'b1, 3'd2, 3'd0, 3'd0, 8'd1));
        wr(4'd2, enc(K_EXEC, C_SUB, 1'b1, 1'b1, 3'd1, 3'd1, 3'd2, 8'd0));
        wr(4'd3, enc(K_BRZ,  4'd0,  1'b0, 1'b0, 3'd0, 3'd0, 3'd1, 8'd5));
        wr(4'd4, enc(K_JMP,  4'd0,  1'b0, 1'b0, 3'd0, 3'd0, 3'd0, 8'd2));
        wr(4'd5, enc(K_HALT, 4'd0,  1'b0, 1'b0, 3'd0, 3'd0, 3'd0, 8'd0));
    endtask

    // Monitor: every Done pulse is matched against the oldest expected run.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && done === 1'b1) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_done", {31'd0, done}, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check({e.name, "_latency"}, cyc - e.start, e.lat);
                    check({e.name, "_steps"}, {24'd0, steps}, {24'd0, e.steps});
                    check({e.name, "_err"}, {31'd0, err}, {31'd0, e.err});
                    check({e.name, "_carryflag"}, {31'd0, carry_flag}, {31'd0, e.cf});
                    check({e.name, "_busy"}, {31'd0, busy}, 32'd0);
                    check({e.name, "_reg"}, {24'd0, regs[e.ridx]}, {24'd0, e.rval});
                end
            end
        end
    end

    initial begin
        int w0;
        bit found;
        rst_n = 1'b0; calc_clr = 1'b1; start = 1'b0;
        prog_we = 1'b0; prog_addr = '0; prog_data = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1; calc_clr = 1'b0;
        @(negedge clk);

        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_err", {31'd0, err}, 32'd0);
        check("rst_carryflag", {31'd0, carry_flag}, 32'd0);
        check("rst_steps", {24'd0, steps}, 32'd0);
        check("rst_calc_outs", {9'd0, wen, rw, rx, ry, data_in, sel, ctrl}, 32'd0);

        // R1 = 0 + 5; R2 = R1 + R1; HALT written in the Start cycle.
        wr(4'd0, enc(K_EXEC, C_ADD, 1'b0, 1'b1, 3'd1, 3'd0, 3'd0, 8'd5));
        wr(4'd1, enc(K_EXEC, C_ADD, 1'b1, 1'b1, 3'd2, 3'd1, 3'd1, 8'd0));
        start_run(1, "add_chain", 6, 8'd3, 1'b0, 1'b0, 2, 8'd10,
                  1, 4'd2, enc(K_HALT, 4'd0, 1'b0, 1'b0, 3'd0, 3'd0, 3'd0, 8'd0));
        // Busy now: this write and Start must both be dropped.
        prog_we = 1'b1; prog_addr = 4'd1;
        prog_data = enc(K_JMP, 4'd0, 1'b0, 1'b0, 3'd0, 3'd0, 3'd0, 8'd0);
        start = 1'b1;
        @(negedge clk);
        prog_we = 1'b0; start = 1'b0;
        wait_run("add_chain", 40);
        start_run(1, "add_rerun", 6, 8'd3, 1'b0, 1'b0, 2, 8'd10, 0, 4'd0, 26'd0);
        wait_run("add_rerun", 40);

        // PC wrap: BRZ taken to 15, EXEC at 15 wraps to 0, BRZ not taken, HALT.
        wr(4'd0, enc(K_BRZ, 4'd0, 1'b0, 1'b0, 3'd0, 3'd0, 3'd3, 8'd15));
        wr(4'd1, enc(K_HALT, 4'd0, 1'b0, 1'b0, 3'd0, 3'd0, 3'd0, 8'd0));
        wr(4'd15, enc(K_EXEC, C_ADD, 1'b0, 1'b1, 3'd3, 3'd0, 3'd0, 8'd7));
        start_run(1, "wrap", 8, 8'd4, 1'b0, 1'b0, 3, 8'd7, 0, 4'd0, 26'd0);
        wait_run("wrap", 40);

        load_countdown();
        start_run(1, "countdown", 22, 8'd11, 1'b0, 1'b0, 1, 8'd0, 0, 4'd0, 26'd0);
        wait_run("countdown", 60);

        // 0x80 + 0x80 carries out; R2 wraps to 0.
        wr(4'd0, enc(K_EXEC, C_ADD, 1'b0, 1'b1, 3'd1, 3'd0, 3'd0, 8'h80));
        wr(4'd1, enc(K_EXEC, C_ADD, 1'b0, 1'b1, 3'd2, 3'd1, 3'd0, 8'h80));
        wr(4'd2, enc(K_HALT, 4'd0, 1'b0, 1'b0, 3'd0, 3'd0, 3'd0, 8'd0));
        start_run(1, "carry", 6, 8'd3, 1'b0, 1'b1, 2, 8'h00, 0, 4'd0, 26'd0);
        wait_run("carry", 40);

        wr(4'd0, enc(K_HALT, 4'd0, 1'b0, 1'b0, 3'd0, 3'd0, 3'd0, 8'd0));
        start_run(1, "carry_clear", 2, 8'd1, 1'b0, 1'b0, 2, 8'h00, 0, 4'd0, 26'd0);
        wait_run("carry_clear", 20);

        // Watchdog: JMP 0 forever.
        wr(4'd0, enc(K_JMP, 4'd0, 1'b0, 1'b0, 3'd0, 3'd0, 3'd0, 8'd0));
        w0 = wen_cnt;
        start_run(1, "watchdog", 510, 8'd255, 1'b1, 1'b0, 1, 8'h80, 0, 4'd0, 26'd0);
        wait_run("watchdog", 600);
        check("watchdog_wen_count", wen_cnt - w0, 32'd0);
        repeat (3) @(negedge clk);
        check("watchdog_err_held", {31'd0, err}, 32'd1);
        check("watchdog_steps_held", {24'd0, steps}, 32'd255);

        // Reset during the first EXEC with WE=1.
        load_countdown();
        start_run(0, "abort", 0, 8'd0, 1'b0, 1'b0, 0, 8'd0, 0, 4'd0, 26'd0);
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            if (wen === 1'b1) found = 1'b1;
            else @(negedge clk);
        end
        check("abort_wen_seen", {31'd0, found}, 32'd1);
        check("abort_err_cleared", {31'd0, err}, 32'd0);
        rst_n = 1'b0;
        @(negedge clk);
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_done", {31'd0, done}, 32'd0);
        check("abort_steps", {24'd0, steps}, 32'd0);
        check("abort_calc_outs", {9'd0, wen, rw, rx, ry, data_in, sel, ctrl}, 32'd0);
        @(negedge clk);
        check("abort_done_late", {31'd0, done}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("abort_done_after_release", {31'd0, done}, 32'd0);
        start_run(1, "abort_rerun", 22, 8'd11, 1'b0, 1'b0, 1, 8'd0, 0, 4'd0, 26'd0);
        wait_run("abort_rerun", 60);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
